// File: rtl/riscv_pkg.sv
// Shared encodings for the integer pipeline: writeback result sources and load funct3 codes.
package riscv_pkg;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word out of an aligned memory word, extends it,
// and flags accesses that straddle their natural alignment.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = read_data[{off, 3'b000} +: 8];
    assign half_lane = off[1] ? read_data[31:16] : read_data[15:0];

    // Unknown funct3 codes behave as a full-word load.
    always_comb begin
        data     = read_data;
        misalign = (off != 2'b00);
        case (funct3)
            FUNCT3_LB: begin
                data     = {{(XLEN-8){byte_lane[7]}}, byte_lane};
                misalign = 1'b0;
            end
            FUNCT3_LBU: begin
                data     = {{(XLEN-8){1'b0}}, byte_lane};
                misalign = 1'b0;
            end
            FUNCT3_LH: begin
                data     = {{(XLEN-16){half_lane[15]}}, half_lane};
                misalign = off[0];
            end
            FUNCT3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, half_lane};
                misalign = off[0];
            end
            default: begin
                data     = read_data;
                misalign = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback result mux and retired-instruction counter
// feeding the register-file write port.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic             M_VALID,
    output logic             M_READY,
    input  logic             M_REG_WRITE,
    input  logic [4:0]       M_RD,
    input  logic [1:0]       M_RESULT_SRC,
    input  logic [2:0]       M_FUNCT3,
    input  logic [XLEN-1:0]  M_ALU_RESULT,
    input  logic [XLEN-1:0]  M_READ_DATA,
    input  logic [XLEN-1:0]  M_PC_PLUS4,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD3,
    output logic             W_FWD_VALID,
    output logic             MISALIGN,
    output logic [CNT_W-1:0] INSTRET
);

    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
    logic [CNT_W-1:0] instret;

    logic [XLEN-1:0] load_data;
    logic            load_misalign;
    logic            misalign;

    assign M_READY = ~STALL | FLUSH;

    // The counter looks at the entry leaving WB, so a flush still retires the current
    // valid entry unless it is also being stalled in place.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid      <= 1'b0;
            reg_write  <= 1'b0;
            rd         <= '0;
            result_src <= '0;
            funct3     <= '0;
            alu_result <= '0;
            read_data  <= '0;
            pc_plus4   <= '0;
            instret    <= '0;
        end else begin
            if (valid && !STALL)
                instret <= instret + 1'b1;
            if (FLUSH) begin
                valid <= 1'b0;
            end else if (!STALL) begin
                valid      <= M_VALID;
                reg_write  <= M_REG_WRITE;
                rd         <= M_RD;
                result_src <= M_RESULT_SRC;
                funct3     <= M_FUNCT3;
                alu_result <= M_ALU_RESULT;
                read_data  <= M_READ_DATA;
                pc_plus4   <= M_PC_PLUS4;
            end
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3    (funct3),
        .off       (alu_result[1:0]),
        .read_data (read_data),
        .data      (load_data),
        .misalign  (load_misalign)
    );

    // Derived purely from captured fields, so it changes only when a new entry is loaded.
    assign misalign = load_misalign & (result_src == RESULT_SRC_LOAD);

    always_comb begin
        WD3 = alu_result;
        case (result_src)
            RESULT_SRC_LOAD: WD3 = load_data;
            RESULT_SRC_PC4:  WD3 = pc_plus4;
            default:         WD3 = alu_result;
        endcase
    end

    assign WE3         = valid & reg_write & (rd != 5'd0) & ~misalign;
    assign A3          = rd;
    assign W_FWD_VALID = WE3;
    assign MISALIGN    = misalign;
    assign INSTRET     = instret;

endmodule
